// File: rtl/fr_ether100_tx.sv
// 100 Mb/s MII transmitter: preamble, SFD, payload, zero pad, FCS, inter-frame gap.
// Nibble timing advances only on the TX_CLK edge strobe.
module fr_ether100_tx (
    input  logic        System_Clock,
    input  logic        Reset,
    input  logic        TxClk_Edge_at_System_Clock,
    input  logic        Frame_Start,
    input  logic [7:0]  Byte_Input,
    input  logic        Byte_Input_Last,
    output logic        Byte_Request_Strobe,
    output logic [3:0]  Tx_Data_nibble_output,
    output logic        Tx_En,
    output logic        Busy,
    output logic        Packet_Good_End,
    output logic        Packet_bad_End,
    output logic [31:0] CRC_out
);

    typedef enum logic [2:0] {
        IDLE, PREAMBLE, SFD, DATA, PAD, FCS, GAP
    } state_t;

    localparam logic [11:0] MIN_BYTES = 12'd60;
    localparam logic [11:0] MAX_BYTES = 12'd1514;

    state_t      state;
    logic [4:0]  cnt;
    logic [7:0]  byte_reg;
    logic        last_reg;
    logic        hi_phase;
    logic [11:0] byte_cnt;
    logic        good_pend;
    logic        bad_pend;
    logic [7:0]  src_byte;
    logic        src_last;
    logic [3:0]  nib;

    function automatic logic [31:0] crc_nibble(input logic [31:0] c,
                                               input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 4; i++)
            r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
        return r;
    endfunction

    // A byte can be consumed in the same cycle it is being captured.
    assign src_byte = Byte_Request_Strobe ? Byte_Input : byte_reg;
    assign src_last = Byte_Request_Strobe ? Byte_Input_Last : last_reg;
    assign nib      = hi_phase ? src_byte[7:4] : src_byte[3:0];
    assign Busy     = (state != IDLE);

    always_ff @(posedge System_Clock or posedge Reset) begin
        if (Reset) begin
            state                 <= IDLE;
            cnt                   <= '0;
            byte_reg              <= '0;
            last_reg              <= 1'b0;
            hi_phase              <= 1'b0;
            byte_cnt              <= '0;
            good_pend             <= 1'b0;
            bad_pend              <= 1'b0;
            Byte_Request_Strobe   <= 1'b0;
            Tx_Data_nibble_output <= '0;
            Tx_En                 <= 1'b0;
            Packet_Good_End       <= 1'b0;
            Packet_bad_End        <= 1'b0;
            CRC_out               <= 32'hFFFFFFFF;
        end else begin
            Byte_Request_Strobe <= 1'b0;
            Packet_Good_End     <= 1'b0;
            Packet_bad_End      <= 1'b0;
            if (Byte_Request_Strobe) begin
                byte_reg <= Byte_Input;
                last_reg <= Byte_Input_Last;
                byte_cnt <= (byte_cnt == 12'hFFF) ? byte_cnt : byte_cnt + 12'd1;
            end
            if (state == IDLE) begin
                if (Frame_Start) begin
                    state <= PREAMBLE;
                    cnt   <= '0;
                end
            end else if (TxClk_Edge_at_System_Clock) begin
                unique case (state)
                    PREAMBLE: begin
                        Tx_En                 <= 1'b1;
                        Tx_Data_nibble_output <= 4'h5;
                        cnt                   <= cnt + 5'd1;
                        if (cnt == 5'd14)
                            state <= SFD;
                    end
                    SFD: begin
                        Tx_Data_nibble_output <= 4'hD;
                        CRC_out               <= 32'hFFFFFFFF;
                        Byte_Request_Strobe   <= 1'b1;
                        hi_phase              <= 1'b0;
                        byte_cnt              <= '0;
                        state                 <= DATA;
                    end
                    DATA: begin
                        Tx_Data_nibble_output <= nib;
                        CRC_out               <= crc_nibble(CRC_out, nib);
                        hi_phase              <= ~hi_phase;
                        if (hi_phase) begin
                            if (src_last) begin
                                state <= (byte_cnt < MIN_BYTES) ? PAD : FCS;
                                cnt   <= '0;
                            end else if (byte_cnt >= MAX_BYTES) begin
                                state    <= GAP;
                                cnt      <= '0;
                                bad_pend <= 1'b1;
                            end else begin
                                Byte_Request_Strobe <= 1'b1;
                            end
                        end
                    end
                    PAD: begin
                        Tx_Data_nibble_output <= 4'h0;
                        CRC_out               <= crc_nibble(CRC_out, 4'h0);
                        hi_phase              <= ~hi_phase;
                        if (hi_phase) begin
                            byte_cnt <= byte_cnt + 12'd1;
                            if (byte_cnt >= MIN_BYTES - 12'd1) begin
                                state <= FCS;
                                cnt   <= '0;
                            end
                        end
                    end
                    FCS: begin
                        Tx_Data_nibble_output <= ~CRC_out[{cnt[2:0], 2'b00} +: 4];
                        cnt                   <= cnt + 5'd1;
                        if (cnt == 5'd7) begin
                            state     <= GAP;
                            cnt       <= '0;
                            good_pend <= 1'b1;
                        end
                    end
                    GAP: begin
                        Tx_En                 <= 1'b0;
                        Tx_Data_nibble_output <= 4'h0;
                        Packet_Good_End       <= good_pend;
                        Packet_bad_End        <= bad_pend;
                        good_pend             <= 1'b0;
                        bad_pend              <= 1'b0;
                        cnt                   <= cnt + 5'd1;
                        if (cnt == 5'd23)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fr_ether100_tx.sv
// Bench for fr_ether100_tx: random payloads against a byte-level frame model.
// The model builds each expected wire nibble stream from payload, pad and FCS rules.
module tb_fr_ether100_tx;

    typedef logic [7:0] bq_t[$];

    logic        System_Clock = 1'b0;
    logic        Reset;
    logic        TxClk_Edge_at_System_Clock;
    logic        Frame_Start;
    logic [7:0]  Byte_Input;
    logic        Byte_Input_Last;
    logic        Byte_Request_Strobe;
    logic [3:0]  Tx_Data_nibble_output;
    logic        Tx_En;
    logic        Busy;
    logic        Packet_Good_End;
    logic        Packet_bad_End;
    logic [31:0] CRC_out;

    fr_ether100_tx dut (
        .System_Clock              (System_Clock),
        .Reset                     (Reset),
        .TxClk_Edge_at_System_Clock(TxClk_Edge_at_System_Clock),
        .Frame_Start               (Frame_Start),
        .Byte_Input                (Byte_Input),
        .Byte_Input_Last           (Byte_Input_Last),
        .Byte_Request_Strobe       (Byte_Request_Strobe),
        .Tx_Data_nibble_output     (Tx_Data_nibble_output),
        .Tx_En                     (Tx_En),
        .Busy                      (Busy),
        .Packet_Good_End           (Packet_Good_End),
        .Packet_bad_End            (Packet_bad_End),
        .CRC_out                   (CRC_out)
    );

    always #5 System_Clock = ~System_Clock;

    int n_assert = 0;
    int n_fail   = 0;

    bq_t        payload;
    bit         has_last;
    logic [3:0] exp_q[$];
    logic [3:0] rx[$];
    int  frames_done = 0;
    int  gap_run     = 0;
    int  last_gap    = 0;
    int  gap_at_idle = 0;
    int  req_cnt     = 0;
    int  good_cnt    = 0;
    int  bad_cnt     = 0;
    int  txd_bad     = 0;
    int  idx         = 0;
    int  div         = 0;
    bit  in_frame    = 0;
    bit  req_seen    = 0;
    bit  busy_q      = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_bytes(input bq_t b);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        foreach (b[i])
            for (int k = 0; k < 8; k++)
                if (c[0] ^ b[i][k]) c = (c >> 1) ^ 32'hEDB88320;
                else c = c >> 1;
        return c;
    endfunction

    function automatic logic [31:0] bitrev(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) r[i] = v[31-i];
        return r;
    endfunction

    // Edge strobe generator, byte source and wire monitor.
    initial begin
        TxClk_Edge_at_System_Clock = 1'b0;
        Byte_Input      = 8'h00;
        Byte_Input_Last = 1'b0;
        forever begin
            @(negedge System_Clock);
            if (TxClk_Edge_at_System_Clock) begin
                if (Tx_En) begin
                    if (!in_frame) begin
                        in_frame = 1;
                        rx.delete();
                        last_gap = gap_run;
                    end
                    rx.push_back(Tx_Data_nibble_output);
                end else begin
                    if (in_frame) begin
                        in_frame = 0;
                        frames_done++;
                        gap_run = 0;
                    end
                    gap_run++;
                    if (Tx_Data_nibble_output !== 4'h0) txd_bad++;
                end
            end
            if (Busy && !busy_q) idx = 0;
            if (!Busy && busy_q) gap_at_idle = gap_run;
            busy_q = Busy;
            if (req_seen) idx++;
            req_seen = Byte_Request_Strobe;
            if (Byte_Request_Strobe) req_cnt++;
            if (Packet_Good_End) good_cnt++;
            if (Packet_bad_End) bad_cnt++;
            Byte_Input = (idx < payload.size()) ? payload[idx] : 8'h00;
            Byte_Input_Last = has_last && (idx == payload.size() - 1);
            div = (div + 1) % 4;
            TxClk_Edge_at_System_Clock = (div == 0);
        end
    end

    task automatic step();
        @(negedge System_Clock);
        #1;
    endtask

    task automatic fill_random(input int len, input bit last_flag);
        payload = {};
        for (int i = 0; i < len; i++) payload.push_back(8'($urandom));
        has_last = last_flag;
    endtask

    task automatic build_expected();
        bq_t body;
        logic [31:0] fcs;
        body = {};
        if (has_last) begin
            body = payload;
            while (body.size() < 60) body.push_back(8'h00);
        end else begin
            for (int i = 0; i < 1514; i++) body.push_back(payload[i]);
        end
        exp_q = {};
        repeat (15) exp_q.push_back(4'h5);
        exp_q.push_back(4'hD);
        foreach (body[i]) begin
            exp_q.push_back(body[i][3:0]);
            exp_q.push_back(body[i][7:4]);
        end
        if (has_last) begin
            fcs = ~crc_bytes(body);
            for (int i = 0; i < 8; i++) exp_q.push_back(fcs[4*i +: 4]);
        end
    endtask

    task automatic check_frame(input string tag);
        int mism;
        logic [31:0] c;
        mism = 0;
        chk({tag, "_len"}, rx.size(), exp_q.size());
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
            if (rx[i] !== exp_q[i]) mism++;
        chk({tag, "_nibbles"}, mism, 0);
        if (has_last) begin
            c = 32'hFFFFFFFF;
            for (int i = 16; i < rx.size(); i++)
                for (int k = 0; k < 4; k++)
                    if (c[0] ^ rx[i][k]) c = (c >> 1) ^ 32'hEDB88320;
                    else c = c >> 1;
            chk({tag, "_residue"}, bitrev(c), 32'hC704DD7B);
        end
    endtask

    task automatic wait_frames(input int n, input int budget);
        int k;
        k = 0;
        while (frames_done < n && k < budget) begin step(); k++; end
        chk("frame_timeout", (frames_done >= n) ? 1 : 0, 1);
    endtask

    task automatic wait_idle(input int budget);
        int k;
        k = 0;
        while (Busy && k < budget) begin step(); k++; end
        chk("idle_timeout", Busy, 0);
    endtask

    task automatic pulse_start();
        Frame_Start = 1'b1;
        step();
        Frame_Start = 1'b0;
    endtask

    task automatic run_frame(input string tag, input bit poke);
        int f0, g0, b0, r0;
        f0 = frames_done;
        g0 = good_cnt;
        b0 = bad_cnt;
        r0 = req_cnt;
        build_expected();
        pulse_start();
        if (poke) begin
            repeat (120) step();
            pulse_start();
        end
        wait_frames(f0 + 1, 20000);
        wait_idle(400);
        check_frame(tag);
        chk({tag, "_good"}, good_cnt - g0, has_last ? 1 : 0);
        chk({tag, "_bad"}, bad_cnt - b0, has_last ? 0 : 1);
        chk({tag, "_reqs"}, req_cnt - r0, has_last ? payload.size() : 1514);
        chk({tag, "_gap"}, gap_at_idle, 24);
        if (poke) begin
            repeat (60) step();
            chk({tag, "_no_restart"}, Busy, 0);
            chk({tag, "_one_frame"}, frames_done - f0, 1);
        end
    endtask

    initial begin
        int f0, g0, b0, r0, k;
        int lens[4];
        Reset       = 1'b1;
        Frame_Start = 1'b0;
        payload     = {};
        has_last    = 1'b1;
        step();
        chk("rst_tx_en", Tx_En, 0);
        chk("rst_txd", Tx_Data_nibble_output, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_crc", CRC_out, 32'hFFFFFFFF);
        chk("rst_req", Byte_Request_Strobe, 0);
        chk("rst_ends", {Packet_Good_End, Packet_bad_End}, 0);
        repeat (3) step();
        Reset = 1'b0;
        repeat (4) step();

        payload = {};
        for (int i = 0; i < 64; i++) payload.push_back(8'(i));
        has_last = 1'b1;
        run_frame("ramp64", 0);
        chk("ramp64_strobes", rx.size(), 152);
        chk("ramp64_d0", {rx[16], rx[17]}, 8'h00);
        chk("ramp64_dlast", {rx[142], rx[143]}, 8'hF3);

        fill_random(5, 1);
        run_frame("pad5", 1);
        chk("pad5_strobes", rx.size(), 144);

        lens[0] = 59;
        lens[1] = 60;
        lens[2] = 61;
        lens[3] = $urandom_range(1, 200);
        foreach (lens[i]) begin
            fill_random(lens[i], 1);
            run_frame($sformatf("len%0d", lens[i]), 0);
        end

        fill_random(1515, 0);
        run_frame("abort", 0);
        chk("abort_strobes", rx.size(), 16 + 3028);

        fill_random(20, 1);
        build_expected();
        f0 = frames_done;
        g0 = good_cnt;
        Frame_Start = 1'b1;
        wait_frames(f0 + 1, 2000);
        check_frame("held1");
        k = 0;
        while (!in_frame && k < 400) begin step(); k++; end
        chk("held_restart", in_frame, 1);
        Frame_Start = 1'b0;
        chk("held_gap", last_gap, 24);
        wait_frames(f0 + 2, 2000);
        wait_idle(400);
        check_frame("held2");
        chk("held_good", good_cnt - g0, 2);

        fill_random(100, 1);
        b0 = bad_cnt;
        r0 = req_cnt;
        pulse_start();
        k = 0;
        while (req_cnt - r0 < 3 && k < 2000) begin step(); k++; end
        chk("rst_mid_in_data", (req_cnt - r0 >= 3) ? 1 : 0, 1);
        Reset = 1'b1;
        #1;
        chk("rst_mid_tx_en", Tx_En, 0);
        chk("rst_mid_busy", Busy, 0);
        chk("rst_mid_txd", Tx_Data_nibble_output, 0);
        chk("rst_mid_crc", CRC_out, 32'hFFFFFFFF);
        step();
        step();
        Reset = 1'b0;
        repeat (20) step();
        chk("rst_mid_no_bad", bad_cnt - b0, 0);
        chk("rst_mid_idle", Busy, 0);
        fill_random(70, 1);
        run_frame("after_rst", 0);

        chk("txd_zero_when_off", txd_bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/fr_ether100_tx.md
FR_ETHER100_TX -- requirements
Module: fr_ether100_tx

Interface
REQ-001 System_Clock  in  1  FPGA clock; sole clock of the block.
REQ-002 Reset  in  1  asynchronous, active-high; clears all state and outputs.
REQ-003 TxClk_Edge_at_System_Clock  in  1  one-System_Clock pulse per MII TX_CLK period; all nibble timing advances only on this strobe.
REQ-004 Frame_Start  in  1  request to send a frame; honoured only in IDLE.
REQ-005 Byte_Input  in  8  payload byte (destination MAC through last data byte); excludes preamble, SFD and FCS.
REQ-006 Byte_Input_Last  in  1  marks Byte_Input as the final payload byte.
REQ-007 Byte_Request_Strobe  out  1  one-cycle pulse; Byte_Input/Byte_Input_Last are sampled in this cycle.
REQ-008 Tx_Data_nibble_output  out  4  MII TXD; bit 0 is first on the wire.
REQ-009 Tx_En  out  1  MII TX_EN.
REQ-010 Busy  out  1  high in every state except IDLE.
REQ-011 Packet_Good_End  out  1  one-cycle pulse after the last FCS nibble is driven.
REQ-012 Packet_bad_End  out  1  one-cycle pulse on a length abort.
REQ-013 CRC_out  out  32  running CRC register; debug/virtual pin.

Function
REQ-014 States SHALL be IDLE, PREAMBLE, SFD, DATA, PAD, FCS, GAP; all transitions occur only in cycles with TxClk_Edge_at_System_Clock=1, except the IDLE->PREAMBLE arm described in REQ-015.
REQ-015 IDLE: Frame_Start=1 arms the frame; the first preamble nibble is driven at the next edge strobe. Frame_Start outside IDLE SHALL be ignored.
REQ-016 Nibble outputs and Tx_En SHALL be registered and change in the System_Clock cycle following the edge strobe (latency 1 cycle).
REQ-017 PREAMBLE SHALL drive 15 nibbles of 0x5; SFD SHALL drive one nibble of 0xD. Tx_En=1 from the first preamble nibble through the last FCS nibble, with no gaps.
REQ-018 Byte handshake: the first Byte_Request_Strobe SHALL occur on the edge strobe that drives SFD. Each later strobe SHALL occur on the edge strobe that drives the high nibble of the current byte. Each byte is sent low nibble first.
REQ-019 After a byte with Byte_Input_Last=1, no further strobes SHALL be issued. The source SHALL hold valid data in every strobe cycle; there is no underrun detection.
REQ-020 Payload count 12 bits, saturating. If the count is below 60 when the last byte is sent, PAD SHALL send 0x00 bytes until the count reaches 60.
REQ-021 CRC: polynomial 0x04C11DB7, reflected, 4 bits per edge strobe, preset 0xFFFFFFFF on the SFD edge. It covers payload and pad only.
REQ-022 FCS SHALL send ~CRC as 8 nibbles, CRC bits [3:0] first through [31:28], with no extra bit reversal inside a nibble.
REQ-023 Length abort: if byte 1514 is consumed without Byte_Input_Last:
  - Tx_En SHALL drop at the next edge strobe;
  - no FCS is sent;
  - Packet_bad_End SHALL pulse;
  - the state SHALL go to GAP.
REQ-024 GAP: Tx_En=0, TXD=0 for 24 edge strobes (96 bit times); then IDLE. Frame_Start held high through GAP SHALL start the next frame immediately on entering IDLE.
REQ-025 When Tx_En=0, Tx_Data_nibble_output SHALL be 0x0.

Reset
REQ-026 On Reset=1, immediately and independently of the clock:
  - state=IDLE;
  - Tx_En=0, TXD=0, Busy=0;
  - all strobes and pulses=0;
  - CRC=0xFFFFFFFF;
  - counters=0.
REQ-027 Reset mid-frame SHALL drop Tx_En in the same cycle. No Packet_bad_End pulse and no GAP are generated.

Verification
REQ-028 Frame_Start, then a 64-byte payload 0x00..0x3F, edge strobe every 4 cycles -> 15x0x5, 0xD, 128 data nibbles (first two 0x0,0x0; last two 0xF,0x3), 8 FCS nibbles; Tx_En high for 152 strobes; one Packet_Good_End pulse.
REQ-029 Loop back to the receiver -> Packet_Good_End at the receiver. CRC computed over data+FCS equals residue 0xC704DD7B.
REQ-030 5-byte payload -> exactly 5 Byte_Request_Strobe pulses; 55 pad bytes of 0x00; Tx_En high for 144 strobes (16+120+8).
REQ-031 Payload of 1515 bytes with no Last -> Tx_En drops after nibble 16+3028; Packet_bad_End=1 for one cycle; 24-strobe GAP; then IDLE.
REQ-032 Frame_Start held high continuously -> Tx_En low for exactly 24 strobes between consecutive frames.
REQ-033 Reset pulsed during DATA -> Tx_En=0 and Busy=0 with no clock edge. A new Frame_Start after release produces a complete, correct frame.
